pipe_ifu: RTL
=============

// Module: pipe_ifu
// PURPOSE
//   Instruction-fetch stage feeding pipe_idu; first stage of the pipeline.
//   Owns the architectural fetch PC and issues one request at a time to the instruction memory.
//   Captures each returned instruction as {pc, inst}, packs it in ifToId_t and hands it to the decode stage over a valid/ready handshake.
//   Accepts a flush plus redirect PC from the execute stage and discards any wrong-path fetch.
// PARAMETERS
//   RESET_PC   32'h8000_0000   first fetch address after reset; bits[1:0] must be 0
// PORTS
//   clk_i             in   1    single clock, rising edge
//   rst_i             in   1    reset, synchronous, active-high
//   flush_i           in   1    redirect request from execute stage
//   redirect_pc_i     in   32   new fetch PC; sampled only when flush_i=1
//   imem_req_valid_o  out  1    fetch request valid
//   imem_req_ready_i  in   1    memory accepts request
//   imem_req_addr_o   out  32   fetch address
//   imem_resp_valid_i in   1    response valid (no back-pressure; one-cycle pulse)
//   imem_resp_inst_i  in   32   fetched instruction
//   if_valid_o        out  1    ifToId_o holds a valid instruction
//   id_ready_i        in   1    decode stage accepts
//   ifToId_o          out  64   ifToId_t {pc, inst} (liang_pkg)
// BEHAVIOUR
//   Reset (rst_i=1 at posedge):
//   - pc_q=RESET_PC, state=REQ, drop_q=0, all buffer entries invalid.
//   - Outputs while in reset: imem_req_valid_o=0, if_valid_o=0, ifToId_o='0.
//   - Reset mid-operation aborts everything. A response for a pre-reset request arrives while state=REQ and is ignored.
//   States:
//   - REQ: imem_req_valid_o = space && ~flush_i && ~rst_i; imem_req_addr_o = pc_q.
//     On valid&&ready -> WAIT. Otherwise stay.
//   - WAIT: await imem_resp_valid_i.
//     On resp: write {pc_q, inst} into the output buffer, pc_q <= pc_q+4 (mod 2^32, FFFF_FFFC wraps to 0), state -> REQ.
//   - DROP: await imem_resp_valid_i. On resp: discard it (no write, pc_q unchanged), state -> REQ.
//   - imem_resp_valid_i is ignored in REQ.
//   Request spacing: at most one outstanding request. REQ->WAIT->REQ gives a minimum of 2 cycles per instruction with zero-wait memory.
//   "space" definition:
//   - Base build (1-entry output register): space = ~out_valid | (if_valid_o & id_ready_i).
//   - The buffer never overflows because a request is only issued when an entry is guaranteed free when the response lands.
//   Output handshake:
//   - if_valid_o = out_valid && ~flush_i.
//   - Transfer when if_valid_o && id_ready_i; the entry is popped that cycle.
//   - ifToId_o holds stable while if_valid_o=1 and id_ready_i=0.
//   - Response write and decode pop in the same cycle are legal: the entry is replaced, valid stays 1.
//   Flush (flush_i=1 at posedge, highest priority after reset):
//   - pc_q <= {redirect_pc_i[31:2], 2'b00}; all buffer entries invalidated.
//   - State: WAIT -> DROP, unless imem_resp_valid_i is high that same cycle, then -> REQ and the response is discarded.
//     DROP stays DROP. REQ stays REQ.
//   - A request cannot be accepted in a flush cycle, because imem_req_valid_o is gated.
//   - Next request issued the cycle after the flush, or after the dropped response arrives.
//   - Back-to-back flushes: the last redirect_pc_i wins.
// CONFIGURATION
//   IFU_FETCH_BUF_EN defined:
//   - Output buffer becomes a 2-entry FIFO (ptr wrap on 1-bit pointers); a request may be issued while one entry is occupied.
//   - space = (count + in_flight) < 2, with pop in the same cycle counted as freeing an entry.
//   - FIFO order preserved. A full FIFO with no pop blocks REQ. Flush empties the FIFO.
//   - Sustains 1 instr / 2 cycles under decode stalls of 1 cycle.
//   IFU_FETCH_BUF_EN undefined: single output register, space as in BEHAVIOUR.
// TESTING
//   1. Reset release, zero-wait mem, id_ready_i=1 -> req addrs 8000_0000, 8000_0004, ...;
//      ifToId_o.pc matches each addr, one instr every 2 cycles.
//   2. id_ready_i=0 for 5 cycles -> if_valid_o stays 1, ifToId_o stable.
//      No request while full (base), or exactly one extra request (BUF_EN); resumes in order.
//   3. flush_i in WAIT with redirect 8000_0100, resp 3 cycles later -> response dropped;
//      next req addr 8000_0100; no if_valid_o for the old PC.
//   4. flush_i in the same cycle as resp_valid -> response discarded, if_valid_o=0 that cycle, next req 8000_0100.
//   5. pc_q=FFFF_FFFC fetch -> next req addr 0000_0000. redirect_pc_i=8000_0103 -> fetch addr 8000_0100.
//   6. rst_i asserted in WAIT, stale resp 1 cycle after release -> ignored; first output pc=RESET_PC.

Source files
------------

// File: rtl/pipe_ifu.sv
// Instruction-fetch stage: owns the fetch PC, issues single outstanding imem requests, hands {pc, inst} to decode.
// Optional IFU_FETCH_BUF_EN turns the single output register into a 2-entry FIFO.
package liang_pkg;
  localparam int unsigned XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } ifToId_t;
endpackage

module pipe_ifu
  import liang_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_valid_o,
  input  logic        imem_req_ready_i,
  output logic [31:0] imem_req_addr_o,
  input  logic        imem_resp_valid_i,
  input  logic [31:0] imem_resp_inst_i,
  output logic        if_valid_o,
  input  logic        id_ready_i,
  output ifToId_t     ifToId_o
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_fire;
  logic        resp_wr;
  logic        pop;
  logic        space;
  logic        out_valid;
  ifToId_t     head;
  ifToId_t     wr_data;
  logic        unused_redirect_lsb;

`ifdef IFU_FETCH_BUF_EN
  ifToId_t [1:0] buf_q, buf_d;
  logic          wr_ptr_q, wr_ptr_d;
  logic          rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          in_flight;

  assign out_valid = (cnt_q != 2'd0);
  assign head      = buf_q[rd_ptr_q];
  assign in_flight = (state_q == S_WAIT);
  // A same-cycle pop frees an entry for the response that lands later.
  assign space     = (3'(cnt_q) + 3'(in_flight) - 3'(pop)) < 3'd2;
`else
  ifToId_t data_q, data_d;
  logic    valid_q, valid_d;

  assign out_valid = valid_q;
  assign head      = data_q;
  assign space     = ~valid_q | pop;
`endif

  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  assign imem_req_valid_o = (state_q == S_REQ) & space & ~flush_i & ~rst_i;
  assign imem_req_addr_o  = pc_q;
  assign req_fire         = imem_req_valid_o & imem_req_ready_i;
  assign if_valid_o       = out_valid & ~flush_i & ~rst_i;
  assign ifToId_o         = rst_i ? '0 : head;
  assign pop              = if_valid_o & id_ready_i;
  assign wr_data          = '{pc: pc_q, inst: imem_resp_inst_i};

  // Next-state for the fetch FSM, PC and output buffer; flush overrides normal progress.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    resp_wr = 1'b0;
    if (flush_i) begin
      pc_d = {redirect_pc_i[31:2], 2'b00};
      unique case (state_q)
        S_WAIT, S_DROP: state_d = imem_resp_valid_i ? S_REQ : S_DROP;
        default:        state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_fire) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid_i) begin
            resp_wr = 1'b1;
            pc_d    = pc_q + 32'd4;
            state_d = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_resp_valid_i) state_d = S_REQ;
        end
        default: state_d = S_REQ;
      endcase
    end

`ifdef IFU_FETCH_BUF_EN
    buf_d    = buf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      cnt_d    = 2'd0;
    end else begin
      if (resp_wr) begin
        buf_d[wr_ptr_q] = wr_data;
        wr_ptr_d        = ~wr_ptr_q;
      end
      if (pop) rd_ptr_d = ~rd_ptr_q;
      cnt_d = cnt_q + 2'(resp_wr) - 2'(pop);
    end
`else
    valid_d = valid_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else begin
      if (pop) valid_d = 1'b0;
      if (resp_wr) begin
        valid_d = 1'b1;
        data_d  = wr_data;
      end
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_REQ;
      pc_q     <= RESET_PC;
`ifdef IFU_FETCH_BUF_EN
      buf_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
`else
      valid_q  <= 1'b0;
      data_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
`ifdef IFU_FETCH_BUF_EN
      buf_q    <= buf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
`else
      valid_q  <= valid_d;
      data_q   <= data_d;
`endif
    end
  end

endmodule
